// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller.
// Optional gate-open timeout is enabled with PARKING_GATE_TIMEOUT_EN.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_UPDATE = 2'd2
    } gate_state_e;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    localparam int DEF_CNT_W       = 4;
    localparam int DEF_CAPACITY    = 15;
    localparam int DEF_OPEN_CYCLES = 8;

endpackage

// File: rtl/occupancy_addsub.sv
// Combinational +/-1 on the occupancy count; co_o is carry on add, borrow on subtract.
module occupancy_addsub #(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] a_i,
    input  logic             sub_i,
    output logic [CNT_W-1:0] y_o,
    output logic             co_o
);

    logic [CNT_W:0] ext;

    always_comb begin
        if (sub_i) begin
            ext = {1'b0, a_i} - (CNT_W+1)'(1);
        end else begin
            ext = {1'b0, a_i} + (CNT_W+1)'(1);
        end
    end

    assign y_o  = ext[CNT_W-1:0];
    assign co_o = ext[CNT_W];

endmodule

// File: rtl/parking_gate_controller.sv
// Single-lane barrier controller: one gate cycle at a time, saturating occupancy count.
// Define PARKING_GATE_TIMEOUT_EN to close the gate after OPEN_CYCLES without a pass.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int CAPACITY    = DEF_CAPACITY,
    parameter int OPEN_CYCLES = DEF_OPEN_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic             gate_open,
    output logic             dir_out,
    output logic [CNT_W-1:0] occupied,
    output logic [CNT_W-1:0] free_slots,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             err
);

    if (CAPACITY < 1 || CAPACITY > (2**CNT_W) - 1 || OPEN_CYCLES < 1) begin : g_bad_params
        $error("parking_gate_controller: invalid CNT_W/CAPACITY/OPEN_CYCLES");
    end

    // Reset asserts asynchronously but releases only after two clean clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    gate_state_e      state_q, state_d;
    logic             dir_q, dir_d;
    logic             reject_q, reject_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] occupied_q, occupied_d;
    logic [CNT_W-1:0] free_q, free_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             timeout;

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    logic [TMR_W-1:0] timer_q, timer_d;

    assign timer_d = (state_q == ST_OPEN) ? timer_q + TMR_W'(1) : '0;
    assign timeout = (timer_q == TMR_W'(OPEN_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    logic [CNT_W-1:0] step_sum;
    logic             step_co;
    logic [CNT_W-1:0] occ_upd;
    logic             err_set;

    occupancy_addsub #(
        .CNT_W (CNT_W)
    ) u_addsub (
        .a_i   (occupied_q),
        .sub_i (dir_q),
        .y_o   (step_sum),
        .co_o  (step_co)
    );

    // Saturate at 0 on exit and at CAPACITY on entry; either overrun flags err.
    always_comb begin
        occ_upd = step_sum;
        err_set = 1'b0;
        if (dir_q == DIR_EXIT) begin
            if (step_co) begin
                occ_upd = occupied_q;
                err_set = 1'b1;
            end
        end else if ({step_co, step_sum} > (CNT_W+1)'(CAPACITY)) begin
            occ_upd = CNT_W'(CAPACITY);
            err_set = 1'b1;
        end
    end

    always_comb begin
        occupied_d = (state_q == ST_UPDATE) ? occ_upd : occupied_q;
        err_d      = err_q | ((state_q == ST_UPDATE) & err_set);
        free_d     = CNT_W'(CAPACITY) - occupied_d;
        full_d     = (occupied_d == CNT_W'(CAPACITY));
        empty_d    = (occupied_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_ENTRY;
            reject_q   <= 1'b0;
            err_q      <= 1'b0;
            occupied_q <= '0;
            free_q     <= CNT_W'(CAPACITY);
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            reject_q   <= reject_d;
            err_q      <= err_d;
            occupied_q <= occupied_d;
            free_q     <= free_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        reject_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (exit_req) begin
                    dir_d   = DIR_EXIT;
                    state_d = ST_OPEN;
                end else if (entry_req) begin
                    if (!full_q) begin
                        dir_d   = DIR_ENTRY;
                        state_d = ST_OPEN;
                    end else begin
                        reject_d = ~reject_q;
                    end
                end
            end
            ST_OPEN: begin
                if (car_passed) begin
                    state_d = ST_UPDATE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        gate_open  = (state_q == ST_OPEN);
        dir_out    = dir_q;
        occupied   = occupied_q;
        free_slots = free_q;
        full       = full_q;
        empty      = empty_q;
        reject     = reject_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with a pass-result scoreboard.
// Follows PARKING_GATE_TIMEOUT_EN the same way the RTL does.
module tb_parking_gate_controller;
    import parking_pkg::*;

    localparam int CNT_W       = 4;
    localparam int CAP         = 15;
    localparam int OPEN_CYCLES = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             entry_req;
    logic             exit_req;
    logic             car_passed;
    logic             gate_open;
    logic             dir_out;
    logic [CNT_W-1:0] occupied;
    logic [CNT_W-1:0] free_slots;
    logic             full;
    logic             empty;
    logic             reject;
    logic             err;

    parking_gate_controller #(
        .CNT_W       (CNT_W),
        .CAPACITY    (CAP),
        .OPEN_CYCLES (OPEN_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .car_passed (car_passed),
        .gate_open  (gate_open),
        .dir_out    (dir_out),
        .occupied   (occupied),
        .free_slots (free_slots),
        .full       (full),
        .empty      (empty),
        .reject     (reject),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int occ;
        int free;
        int full;
        int empty;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_occ   = 0;
    int   model_err   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gate(input logic lvl, input int budget, input string tag);
        int k = 0;
        while (gate_open !== lvl && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(gate_open), 32'(lvl));
    endtask

    task automatic push_pass(input bit is_exit);
        exp_t e;
        if (is_exit) begin
            if (model_occ == 0) model_err = 1;
            else                model_occ--;
        end else begin
            if (model_occ == CAP) model_err = 1;
            else                  model_occ++;
        end
        e.occ   = model_occ;
        e.free  = CAP - model_occ;
        e.full  = (model_occ == CAP) ? 1 : 0;
        e.empty = (model_occ == 0) ? 1 : 0;
        e.err   = model_err;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_occ"},   32'(occupied),   32'(e.occ));
            check({tag, "_free"},  32'(free_slots), 32'(e.free));
            check({tag, "_full"},  32'(full),       32'(e.full));
            check({tag, "_empty"}, 32'(empty),      32'(e.empty));
            check({tag, "_err"},   32'(err),        32'(e.err));
        end
    endtask

    // One full gate cycle: request, open, pass 3 cycles in, count 2 clk later.
    task automatic do_pass(input bit ent, input bit ext, input string tag);
        entry_req = ent;
        exit_req  = ext;
        wait_gate(1'b1, 6, {tag, "_open"});
        entry_req = 1'b0;
        exit_req  = 1'b0;
        check({tag, "_dir"}, 32'(dir_out), 32'(ext));
        tick(2);
        car_passed = 1'b1;
        push_pass(ext);
        tick(1);
        car_passed = 1'b0;
        check({tag, "_closed"}, 32'(gate_open), 32'(0));
        tick(1);
        pop_check(tag);
    endtask

    initial begin
        int cnt;
        rst_n      = 1'b0;
        entry_req  = 1'b0;
        exit_req   = 1'b0;
        car_passed = 1'b0;

        // Reset values
        tick(2);
        check("rst_gate",   32'(gate_open),  32'(0));
        check("rst_dir",    32'(dir_out),    32'(0));
        check("rst_occ",    32'(occupied),   32'(0));
        check("rst_free",   32'(free_slots), 32'(CAP));
        check("rst_full",   32'(full),       32'(0));
        check("rst_empty",  32'(empty),      32'(1));
        check("rst_reject", 32'(reject),     32'(0));
        check("rst_err",    32'(err),        32'(0));
        rst_n = 1'b1;
        tick(3);

        // Single entry
        do_pass(1'b1, 1'b0, "entry1");

        // car_passed outside OPEN is ignored
        car_passed = 1'b1;
        tick(1);
        car_passed = 1'b0;
        tick(2);
        check("idle_pass_occ",  32'(occupied),  32'(model_occ));
        check("idle_pass_gate", 32'(gate_open), 32'(0));

        // Fill to capacity
        for (int i = 0; i < CAP - 1; i++) do_pass(1'b1, 1'b0, "fill");
        check("fill_full", 32'(full), 32'(1));

        // Entry while full: reject every second cycle, gate stays shut
        entry_req = 1'b1;
        tick(1);
        check("rej_p0", 32'(reject), 32'(1));
        check("rej_g0", 32'(gate_open), 32'(0));
        tick(1);
        check("rej_p1", 32'(reject), 32'(0));
        tick(1);
        check("rej_p2", 32'(reject), 32'(1));
        entry_req = 1'b0;
        tick(1);
        check("rej_p3", 32'(reject), 32'(0));
        check("rej_gate", 32'(gate_open), 32'(0));
        check("rej_occ", 32'(occupied), 32'(CAP));

        // Drain to 5, then simultaneous requests: exit wins
        for (int i = 0; i < 10; i++) do_pass(1'b0, 1'b1, "drain");
        check("at5_occ", 32'(occupied), 32'(5));
        do_pass(1'b1, 1'b1, "both");

        // Drain to empty, then exit pass while empty
        for (int i = 0; i < 4; i++) do_pass(1'b0, 1'b1, "drain0");
        do_pass(1'b0, 1'b1, "empty_exit");
        do_pass(1'b1, 1'b0, "err_hold");

        // Gate with no pass; a request during OPEN must not change direction
        entry_req = 1'b1;
        wait_gate(1'b1, 6, "nopass_open");
        entry_req = 1'b0;
        exit_req  = 1'b1;
        cnt = 1;
`ifdef PARKING_GATE_TIMEOUT_EN
        while (gate_open === 1'b1 && cnt < 50) begin
            tick(1);
            exit_req = 1'b0;
            if (gate_open === 1'b1) cnt++;
        end
        check("timeout_cycles", 32'(cnt), 32'(OPEN_CYCLES));
        check("timeout_dir", 32'(dir_out), 32'(DIR_ENTRY));
        tick(2);
        check("timeout_occ", 32'(occupied), 32'(model_occ));
`else
        for (int i = 1; i < 100; i++) begin
            tick(1);
            exit_req = 1'b0;
            if (gate_open === 1'b1) cnt++;
        end
        check("stuck_cycles", 32'(cnt), 32'(100));
        check("stuck_dir", 32'(dir_out), 32'(DIR_ENTRY));
        car_passed = 1'b1;
        push_pass(1'b0);
        tick(1);
        car_passed = 1'b0;
        tick(1);
        pop_check("stuck_pass");
`endif

        // Reset in the middle of a gate cycle
        entry_req = 1'b1;
        wait_gate(1'b1, 6, "midrst_open");
        entry_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_gate",  32'(gate_open),  32'(0));
        check("midrst_occ",   32'(occupied),   32'(0));
        check("midrst_free",  32'(free_slots), 32'(CAP));
        check("midrst_empty", 32'(empty),      32'(1));
        check("midrst_err",   32'(err),        32'(0));
        check("midrst_dir",   32'(dir_out),    32'(0));
        model_occ = 0;
        model_err = 0;
        rst_n = 1'b1;
        tick(4);
        do_pass(1'b1, 1'b0, "post_rst");

        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
